gf_alu_sched: RTL
=================

Name: gf_alu_sched

Overview:
- Command scheduler for one shared combinational GF(2^M) multiplier (gf_mul_classic instance at the parent level).
- Accepts add/mul/div commands over a valid/ready interface and returns one result per command over a valid/ready interface.
- Add is done locally as XOR. Mul uses one multiplier pass.
- Div computes a*b^(2^M-2) by square-and-multiply, sequencing the single multiplier over many cycles. One command is in flight at a time.

Parameters:
- M_P, 8, field width in bits; the multiplier polynomial is owned by the multiplier instance.
- ID_W_P, 4, width of the command tag echoed on the response.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  scheduler can accept a command.
- cmd_op  in  2  operation: 0=add, 1=mul, 2=div, 3=illegal.
- cmd_a  in  M_P  operand a (dividend for div).
- cmd_b  in  M_P  operand b (divisor for div).
- cmd_id  in  ID_W_P  tag, echoed on rsp_id.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  M_P  result.
- rsp_err  out  1  div by zero or illegal op.
- rsp_id  out  ID_W_P  tag of the command.
- mul_x  out  M_P  multiplier operand x.
- mul_y  out  M_P  multiplier operand y.
- mul_p  in  M_P  multiplier product, combinational from mul_x/mul_y in the same cycle.

Behaviour:
- Single clock. Reset is synchronous and active-high: rst sampled high at a rising edge of clk.
- Reset values: state=IDLE, cmd_ready=1 in the following cycle, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_id=0, mul_x=mul_y=0. Internal a_q, r_q, s_q, cnt=0.
- Reset mid-operation aborts the in-flight command with no response; a pending response is dropped.
- States: IDLE, SQ, ACC, FIN, RESP. cmd_ready=1 only in IDLE.
- mul_x/mul_y are registered-state-driven combinational outputs; they are 0 in IDLE and RESP.
- IDLE, on cmd_valid&cmd_ready: latch cmd_id, then dispatch on op:
  - add: rsp_data<=a^b, err=0, -> RESP.
  - mul: a_q<=a, r_q<=b, -> FIN.
  - div, b!=0: a_q<=a, s_q<=b, r_q<=1, cnt<=0, -> SQ.
  - div, b==0: rsp_data<=0, err<=1, -> RESP.
  - op==3: rsp_data<=0, err<=1, -> RESP.
- SQ: mul_x=mul_y=s_q; s_q<=mul_p; -> ACC.
- ACC: mul_x=r_q, mul_y=s_q; r_q<=mul_p; cnt<=cnt+1; -> FIN if cnt==M_P-2, else -> SQ. After M_P-1 SQ/ACC pairs, r_q=b^(2^M-2)=b^-1.
- FIN: mul_x=a_q, mul_y=r_q; rsp_data<=mul_p, err<=0; -> RESP.
- RESP: rsp_valid=1. rsp_data/err/id are held stable until rsp_ready is high. On rsp_valid&rsp_ready -> IDLE, with rsp_valid=0 the next cycle.
- No back-to-back overlap: the next command can be accepted one cycle after the response handshake.
- Latency from the accept edge T to rsp_valid high, with M_P=8:
  - add, error cases: T+1.
  - mul: T+2.
  - div: T+16 (14 SQ/ACC cycles, 1 FIN cycle).
  - General div latency: 2*(M_P-1)+2.
- Division with a=0 and b!=0 returns 0 with err=0. b=1 returns a.
- cmd_* is ignored when cmd_ready=0. Holding cmd_valid through RESP is legal; the command is accepted in the next IDLE cycle.

Test Plan:
- Reset then add a=232, b=46, id=3, rsp_ready=1: rsp_valid at T+1, data=198, err=0, id=3, cmd_ready=0 during RESP.
- Mul a=228, b=214: rsp at T+2, data=88. Mul a=111, b=74: data=67. Check mul_x=228, mul_y=214 in the FIN cycle.
- Div a=236, b=109: rsp_valid exactly at T+16, data=250. Div a=19, b=67: data=179. Div a=0, b=5: data=0, err=0.
- Div a=57, b=0 -> T+1, data=0, err=1. op=3 -> err=1, data=0.
- Backpressure on div a=157, b=46: hold rsp_ready=0 for 10 cycles; data=213 stays stable and cmd_ready stays 0. Release: one handshake, then the next command (add 1^82 -> 83) is accepted.
- Assert rst during SQ of a div: no response, cmd_ready=1 after reset. A following mul 220*60 returns 58.

Source files
------------

// File: rtl/gf_alu_sched.sv
// Command scheduler that time-shares one external combinational GF(2^M) multiplier
// between add (local XOR), mul (one pass) and div (a * b^(2^M-2) by square-and-multiply).
module gf_alu_sched #(
    parameter int M_P    = 8,
    parameter int ID_W_P = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [M_P-1:0]    cmd_a,
    input  logic [M_P-1:0]    cmd_b,
    input  logic [ID_W_P-1:0] cmd_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [M_P-1:0]    rsp_data,
    output logic              rsp_err,
    output logic [ID_W_P-1:0] rsp_id,
    output logic [M_P-1:0]    mul_x,
    output logic [M_P-1:0]    mul_y,
    input  logic [M_P-1:0]    mul_p
);

    localparam int CNT_W = $clog2(M_P) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M_P - 2);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        ACC  = 3'd2,
        FIN  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t              state_reg;
    logic [M_P-1:0]      a_q;
    logic [M_P-1:0]      r_q;
    logic [M_P-1:0]      s_q;
    logic [CNT_W-1:0]    cnt;
    logic [M_P-1:0]      rsp_data_reg;
    logic                rsp_err_reg;
    logic [ID_W_P-1:0]   rsp_id_reg;

    assign cmd_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_id    = rsp_id_reg;

    // Multiplier operands are a pure decode of the current state and working registers.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        unique case (state_reg)
            SQ: begin
                mul_x = s_q;
                mul_y = s_q;
            end
            ACC: begin
                mul_x = r_q;
                mul_y = s_q;
            end
            FIN: begin
                mul_x = a_q;
                mul_y = r_q;
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            a_q          <= '0;
            r_q          <= '0;
            s_q          <= '0;
            cnt          <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            rsp_id_reg   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_id_reg <= cmd_id;
                        if (cmd_op == OP_ADD) begin
                            rsp_data_reg <= cmd_a ^ cmd_b;
                            rsp_err_reg  <= 1'b0;
                            state_reg    <= RESP;
                        end else if (cmd_op == OP_MUL) begin
                            a_q       <= cmd_a;
                            r_q       <= cmd_b;
                            state_reg <= FIN;
                        end else if (cmd_op == OP_DIV && cmd_b != '0) begin
                            a_q       <= cmd_a;
                            s_q       <= cmd_b;
                            r_q       <= M_P'(1);
                            cnt       <= '0;
                            state_reg <= SQ;
                        end else begin
                            // Divide by zero and the reserved opcode both answer immediately.
                            rsp_data_reg <= '0;
                            rsp_err_reg  <= 1'b1;
                            state_reg    <= RESP;
                        end
                    end
                end
                SQ: begin
                    s_q       <= mul_p;
                    state_reg <= ACC;
                end
                ACC: begin
                    r_q <= mul_p;
                    cnt <= cnt + 1'b1;
                    // r_q accumulates b^(2+4+...+2^(M-1)) = b^(2^M-2), the inverse of b.
                    state_reg <= (cnt == CNT_LAST) ? FIN : SQ;
                end
                FIN: begin
                    rsp_data_reg <= mul_p;
                    rsp_err_reg  <= 1'b0;
                    state_reg    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
